// File: rtl/bp_pkg.sv
// Shared definitions for the dynamic branch predictor.
// Provides the predictor mode encodings, the counter reset value and the
// PC-to-index / PC-to-tag extraction helpers used by the lookup and update paths.
package bp_pkg;

  typedef enum logic [1:0] {
    BP_STATIC  = 2'd0,
    BP_BIMODAL = 2'd1,
    BP_GSHARE  = 2'd2
  } bp_mode_e;

  // Weakly-not-taken: one below the taken threshold (0 for a 1-bit counter).
  function automatic int ctr_init(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

  // Table index: the word-aligned PC bits just above the byte offset.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // BTB tag: the PC bits immediately above the index field.
  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w,
                                         input int tag_w);
    return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
  endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Direction table of ENTRIES saturating counters held in flops.
// Ports: clk/reset (sync, active-low), combinational read port (rd_idx ->
// rd_ctr), single update port (wr_en, wr_idx, wr_taken). Reset loads every
// counter with the weakly-not-taken value in one cycle.
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int IDX_W    = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [CTR_BITS-1:0] rd_ctr,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic                wr_taken
);

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d [ENTRIES];
  logic [CTR_BITS-1:0] cur_s;

  // Read returns the pre-update contents (read-before-write).
  assign rd_ctr = ctr_q[rd_idx];
  assign cur_s  = ctr_q[wr_idx];

  // Next-state: saturating step of the addressed counter.
  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      if (wr_taken) begin
        ctr_d[wr_idx] = (cur_s == CTR_MAX) ? cur_s : cur_s + CTR_BITS'(1);
      end else begin
        ctr_d[wr_idx] = (cur_s == CTR_MIN) ? cur_s : cur_s - CTR_BITS'(1);
      end
    end else begin
      ctr_d[wr_idx] = cur_s;
    end
  end

  // Counter storage with single-cycle reset initialisation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor (static-taken / bimodal / gshare) for the IF stage.
// Ports: clk, reset (sync, active-low); lookup_valid/lookup_pc in, with
// predict_taken/predict_target/predict_hit out in the same cycle; EX-stage
// update_* inputs train the direction table, BTB and global history;
// stat_branches / stat_mispredicts count resolved and mispredicted branches.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int TAG_W    = 8,
  parameter int GHR_BITS = 6,
  parameter int MODE     = 1,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lookup_valid,
  input  logic [63:0]       lookup_pc,
  output logic              predict_taken,
  output logic [63:0]       predict_target,
  output logic              predict_hit,
  input  logic              update_valid,
  input  logic [63:0]       update_pc,
  input  logic              update_taken,
  input  logic [63:0]       update_target,
  input  logic              update_mispredict,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] TAKEN_THR = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam bit USE_GHR = (MODE == int'(BP_GSHARE));

  logic                btb_valid_q [ENTRIES];
  logic [TAG_W-1:0]    btb_tag_q   [ENTRIES];
  logic [63:0]         btb_tgt_q   [ENTRIES];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [STAT_W-1:0]   br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  logic [IDX_W-1:0]    ghr_ext_s, lk_btb_idx_s, lk_dir_idx_s, up_btb_idx_s, up_dir_idx_s;
  logic [TAG_W-1:0]    lk_tag_s, up_tag_s;
  logic [CTR_BITS-1:0] lk_ctr_s;
  logic                dir_s;

  // History only folds into the direction index in gshare; zero-extended.
  assign ghr_ext_s    = USE_GHR ? IDX_W'(ghr_q) : '0;
  assign lk_btb_idx_s = IDX_W'(pc_index(lookup_pc, IDX_W));
  assign lk_dir_idx_s = lk_btb_idx_s ^ ghr_ext_s;
  assign lk_tag_s     = TAG_W'(pc_tag(lookup_pc, IDX_W, TAG_W));
  assign up_btb_idx_s = IDX_W'(pc_index(update_pc, IDX_W));
  assign up_dir_idx_s = up_btb_idx_s ^ ghr_ext_s;
  assign up_tag_s     = TAG_W'(pc_tag(update_pc, IDX_W, TAG_W));

  sat_counter_table #(
    .ENTRIES (ENTRIES),
    .CTR_BITS(CTR_BITS),
    .IDX_W   (IDX_W)
  ) u_dir (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (lk_dir_idx_s),
    .rd_ctr  (lk_ctr_s),
    .wr_en   (update_valid),
    .wr_idx  (up_dir_idx_s),
    .wr_taken(update_taken)
  );

  // Counter at or above the threshold is the same as its MSB being set.
  assign dir_s = (MODE == int'(BP_STATIC)) ? 1'b1 : (lk_ctr_s >= TAKEN_THR);

  assign predict_hit    = btb_valid_q[lk_btb_idx_s] && (btb_tag_q[lk_btb_idx_s] == lk_tag_s);
  assign predict_taken  = lookup_valid && predict_hit && dir_s;
  assign predict_target = predict_taken ? btb_tgt_q[lk_btb_idx_s] : lookup_pc + 64'd4;

  assign stat_branches    = br_cnt_q;
  assign stat_mispredicts = mis_cnt_q;

  // Next-state for history and statistics.
  always_comb begin
    ghr_d     = ghr_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (update_valid) begin
      ghr_d     = USE_GHR ? GHR_BITS'({ghr_q, update_taken}) : ghr_q;
      br_cnt_d  = br_cnt_q + STAT_W'(1);
      mis_cnt_d = update_mispredict ? mis_cnt_q + STAT_W'(1) : mis_cnt_q;
    end else begin
      ghr_d     = ghr_q;
    end
  end

  // BTB, history and statistics registers; reset drops any concurrent update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= 64'd0;
      end
      ghr_q     <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (update_valid && update_taken) begin
        btb_valid_q[up_btb_idx_s] <= 1'b1;
        btb_tag_q[up_btb_idx_s]   <= up_tag_s;
        btb_tgt_q[up_btb_idx_s]   <= update_target;
      end
      ghr_q     <= ghr_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic clk = 1'b0;
  logic reset, lookup_valid, update_valid, update_taken, update_mispredict;
  logic [63:0] lookup_pc, update_pc, update_target;
  logic [1:0] pt, ph;
  logic [1:0][63:0] ptg;
  logic [1:0][31:0] sbr, smi;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(64), .CTR_BITS(2), .TAG_W(8), .GHR_BITS(6), .MODE(1), .STAT_W(32)) dut_bi (
    .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_taken(pt[0]), .predict_target(ptg[0]), .predict_hit(ph[0]),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .stat_branches(sbr[0]), .stat_mispredicts(smi[0]));

  branch_predictor #(.ENTRIES(64), .CTR_BITS(2), .TAG_W(8), .GHR_BITS(6), .MODE(2), .STAT_W(32)) dut_gs (
    .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_taken(pt[1]), .predict_target(ptg[1]), .predict_hit(ph[1]),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .stat_branches(sbr[1]), .stat_mispredicts(smi[1]));

  int total = 0;
  int bad = 0;

  // Reference model: model 0 is bimodal, model 1 is gshare (64 entries, 2-bit ctrs).
  int          mctr [2][64];
  bit          mbv  [2][64];
  logic [63:0] mtag [2][64];
  logic [63:0] mtgt [2][64];
  int          mghr [2];
  logic [31:0] msb  [2];
  logic [31:0] msm  [2];
  bit          model_ok = 1'b0;

  // Values seen on the DUTs just before the last clock edge.
  logic [1:0] s_t, s_h;
  logic [1:0][63:0] s_tg;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic m_pred(input int m, input bit lv, input logic [63:0] pc,
                        output bit h, output bit t, output logic [63:0] tg);
    int bi, di;
    bi = int'((pc >> 2) & 64'd63);
    di = bi ^ ((m == 1) ? mghr[1] : 0);
    h  = mbv[m][bi] && (mtag[m][bi] == ((pc >> 8) & 64'd255));
    t  = lv && h && (mctr[m][di] >= 2);
    tg = t ? mtgt[m][bi] : pc + 64'd4;
  endtask

  task automatic m_clock(input bit rs, input bit uv, input logic [63:0] upc,
                         input bit ut, input logic [63:0] utgt, input bit um);
    int bi, di;
    for (int m = 0; m < 2; m++) begin
      if (rs) begin
        for (int i = 0; i < 64; i++) begin
          mctr[m][i] = 1; mbv[m][i] = 1'b0; mtag[m][i] = 64'd0; mtgt[m][i] = 64'd0;
        end
        mghr[m] = 0; msb[m] = 32'd0; msm[m] = 32'd0;
      end else if (uv) begin
        bi = int'((upc >> 2) & 64'd63);
        di = bi ^ ((m == 1) ? mghr[1] : 0);
        if (ut) mctr[m][di] = (mctr[m][di] < 3) ? mctr[m][di] + 1 : 3;
        else    mctr[m][di] = (mctr[m][di] > 0) ? mctr[m][di] - 1 : 0;
        if (ut) begin
          mbv[m][bi] = 1'b1; mtag[m][bi] = (upc >> 8) & 64'd255; mtgt[m][bi] = utgt;
        end
        if (m == 1) mghr[1] = ((mghr[1] << 1) | int'(ut)) & 63;
        msb[m] = msb[m] + 32'd1;
        if (um) msm[m] = msm[m] + 32'd1;
      end
    end
  endtask

  // One cycle: drive, check outputs against the model mid-cycle, clock, advance model.
  task automatic step(input bit rs, input bit lv, input logic [63:0] lpc, input bit uv,
                      input logic [63:0] upc, input bit ut, input logic [63:0] utgt, input bit um);
    bit h, t;
    logic [63:0] tg;
    reset = ~rs; lookup_valid = lv; lookup_pc = lpc; update_valid = uv;
    update_pc = upc; update_taken = ut; update_target = utgt; update_mispredict = um;
    #2;
    s_t = pt; s_h = ph; s_tg = ptg;
    if (model_ok) begin
      for (int m = 0; m < 2; m++) begin
        m_pred(m, lv, lpc, h, t, tg);
        chk($sformatf("m%0d_hit", m), 64'(ph[m]), 64'(h));
        chk($sformatf("m%0d_taken", m), 64'(pt[m]), 64'(t));
        chk($sformatf("m%0d_target", m), ptg[m], tg);
        chk($sformatf("m%0d_stat_br", m), 64'(sbr[m]), 64'(msb[m]));
        chk($sformatf("m%0d_stat_mis", m), 64'(smi[m]), 64'(msm[m]));
      end
    end
    @(posedge clk);
    m_clock(rs, uv, upc, ut, utgt, um);
    if (rs) model_ok = 1'b1;
    #1;
  endtask

  typedef struct {
    bit lv; logic [63:0] lpc;
    bit uv; logic [63:0] upc; bit ut; logic [63:0] utgt; bit um;
    bit et; bit eh; logic [63:0] etg;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(input bit lv, input logic [63:0] lpc, input bit uv,
                              input logic [63:0] upc, input bit ut, input logic [63:0] utgt,
                              input bit um, input bit et, input bit eh, input logic [63:0] etg);
    vec_t v;
    v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.um = um; v.et = et; v.eh = eh; v.etg = etg;
    return v;
  endfunction

  function automatic logic [63:0] rpc();
    logic [63:0] p;
    if ($urandom_range(0, 7) == 0) p = {$urandom, $urandom};
    else p = (64'($urandom_range(0, 3)) << 8) | (64'($urandom_range(0, 63)) << 2);
    return p;
  endfunction

  initial begin
    bit h, t, ut, rs;
    logic [63:0] tg;
    int nmis, late_bad;

    // Bimodal directed table (expectations are for the MODE 1 instance).
    vt[0]  = mk(1, 64'h100, 0, 64'h0,   0, 64'h0,   0, 0, 0, 64'h104);
    vt[1]  = mk(1, 64'h100, 1, 64'h100, 1, 64'h80,  1, 0, 0, 64'h104);
    vt[2]  = mk(1, 64'h100, 1, 64'h100, 1, 64'h80,  0, 1, 1, 64'h80);
    vt[3]  = mk(1, 64'h100, 1, 64'h100, 0, 64'h0,   1, 1, 1, 64'h80);
    vt[4]  = mk(1, 64'h100, 1, 64'h100, 0, 64'h0,   1, 1, 1, 64'h80);
    vt[5]  = mk(1, 64'h100, 0, 64'h0,   0, 64'h0,   1, 0, 1, 64'h104);
    vt[6]  = mk(1, 64'h200, 1, 64'h200, 1, 64'h400, 1, 0, 0, 64'h204);
    vt[7]  = mk(1, 64'h200, 0, 64'h0,   0, 64'h0,   0, 1, 1, 64'h400);
    vt[8]  = mk(0, 64'h200, 0, 64'h0,   0, 64'h0,   0, 0, 1, 64'h204);
    for (int i = 9; i < 14; i++)
      vt[i] = mk(1, 64'h200, 1, 64'h200, 1, 64'h400, 0, 1, 1, 64'h400);
    vt[14] = mk(1, 64'h200, 1, 64'h200, 0, 64'h0,   1, 1, 1, 64'h400);
    vt[15] = mk(1, 64'h200, 0, 64'h0,   0, 64'h0,   0, 1, 1, 64'h400);
    vt[16] = mk(1, 64'h100, 0, 64'h0,   0, 64'h0,   0, 0, 0, 64'h104);
    vt[17] = mk(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0, 64'h0, 0, 0, 0, 64'h0);

    step(1, 0, 64'h0, 1, 64'h100, 1, 64'h80, 1);
    step(1, 0, 64'h0, 0, 64'h0, 0, 64'h0, 0);
    chk("reset_stat_br", 64'(sbr[0]), 64'd0);
    chk("reset_stat_mis", 64'(smi[0]), 64'd0);

    for (int i = 0; i < 18; i++) begin
      step(0, vt[i].lv, vt[i].lpc, vt[i].uv, vt[i].upc, vt[i].ut, vt[i].utgt, vt[i].um);
      chk($sformatf("vec%0d_taken", i), 64'(s_t[0]), 64'(vt[i].et));
      chk($sformatf("vec%0d_hit", i), 64'(s_h[0]), 64'(vt[i].eh));
      chk($sformatf("vec%0d_target", i), s_tg[0], vt[i].etg);
    end
    chk("bi_stat_br", 64'(sbr[0]), 64'd11);
    chk("bi_stat_mis", 64'(smi[0]), 64'd5);

    // Gshare: alternating pattern at 0x300 must be learned.
    step(1, 0, 64'h0, 0, 64'h0, 0, 64'h0, 0);
    nmis = 0; late_bad = 0;
    for (int k = 0; k < 20; k++) begin
      ut = (k % 2 == 0);
      m_pred(1, 1'b1, 64'h300, h, t, tg);
      if (t != ut) nmis++;
      step(0, 1, 64'h300, 1, 64'h300, ut, 64'h340, t != ut);
      if (k >= 12 && s_t[1] != ut) late_bad++;
    end
    chk("gs_late_mispredicts", 64'(late_bad), 64'd0);
    chk("gs_stat_br", 64'(sbr[1]), 64'd20);
    chk("gs_stat_mis", 64'(smi[1]), 64'(nmis));

    // Reset in the middle of traffic, with an update on the same edge.
    step(0, 1, 64'h300, 1, 64'h300, 1, 64'h340, 1);
    step(1, 1, 64'h300, 1, 64'h300, 1, 64'h340, 1);
    update_valid = 1'b0;
    #1;
    chk("rst_mid_hit", 64'(ph[1]), 64'd0);
    chk("rst_mid_target", ptg[1], 64'h304);
    chk("rst_mid_stat_br", 64'(sbr[1]), 64'd0);
    chk("rst_mid_stat_mis", 64'(smi[1]), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      rs = ($urandom_range(0, 63) == 0);
      step(rs, 1'($urandom), rpc(), ($urandom_range(0, 3) != 0), rpc(),
           1'($urandom), {$urandom, $urandom}, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
